// File: rtl/sw_debounce.sv
// -----------------------------------------------------------------------------
// sw_debounce
//
// Conditions N_SW bouncing slide-switch inputs. The module has four stages:
//   1. A 2-flop synchronizer (sync1, sync2) per bit.
//   2. A 21-bit per-bit debounce counter. The counter clears while sync2
//      matches the accepted level.
//   3. Acceptance. sync2 is accepted once it has differed from the accepted
//      level for DEBOUNCE_CYCLES consecutive comparisons.
//   4. A start-up SETTLE/RUN FSM. It masks rise/fall events and rise counting
//      until the settle window has elapsed. This stops switches that are
//      already on at power-up from producing events.
//
// Optional feature: when the macro SW_DEBOUNCE_RISE_CNT_EN is defined, each
// rise_cnt byte is an 8-bit wrapping count of sw_rise pulses. Without the
// macro, rise_cnt is tied to zero and no counter registers exist.
//
// Ports
//   clk        in   1       system clock (125 MHz), rising edge
//   rst        in   1       synchronous, active-high reset
//   sw         in   N_SW    raw switch pins (asynchronous, bouncing)
//   sw_stable  out  N_SW    debounced switch levels
//   sw_rise    out  N_SW    one-cycle pulse on an accepted 0->1 change
//   sw_fall    out  N_SW    one-cycle pulse on an accepted 1->0 change
//   sw_valid   out  1       high once the start-up settle window has elapsed
//   rise_cnt   out  8*N_SW  per-switch rise counters, switch i in [8i+7:8i]
// -----------------------------------------------------------------------------
module sw_debounce #(
    parameter int N_SW            = 2,
    parameter int DEBOUNCE_CYCLES = 1250000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_SW-1:0]     sw,
    output logic [N_SW-1:0]     sw_stable,
    output logic [N_SW-1:0]     sw_rise,
    output logic [N_SW-1:0]     sw_fall,
    output logic                sw_valid,
    output logic [8*N_SW-1:0]   rise_cnt
);

    // Last count value before acceptance, and last settle count before RUN.
    localparam logic [20:0] DEB_LAST    = 21'(DEBOUNCE_CYCLES - 1);
    localparam logic [21:0] SETTLE_LAST = 22'(DEBOUNCE_CYCLES + 1);

    typedef enum logic [0:0] {
        SETTLE = 1'b0,
        RUN    = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [21:0]       settle_cnt_r;
    logic              settle_done_s;
    logic              valid_r;

    logic [N_SW-1:0]   sync1_r;
    logic [N_SW-1:0]   sync2_r;
    logic [N_SW-1:0]   stable_r;
    logic [20:0]       deb_cnt_r [N_SW];
    logic [N_SW-1:0]   differ_s;
    logic [N_SW-1:0]   accept_s;
    logic [N_SW-1:0]   rise_nxt_s;
    logic [N_SW-1:0]   fall_nxt_s;
    logic              events_en_s;
    logic [N_SW-1:0]   rise_r;
    logic [N_SW-1:0]   fall_r;

    // Start-up FSM next-state logic: leave SETTLE after DEBOUNCE_CYCLES+2 edges.
    always_comb begin
        settle_done_s = (settle_cnt_r == SETTLE_LAST);
        state_nxt_s   = state_r;
        case (state_r)
            SETTLE: begin
                if (settle_done_s) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = SETTLE;
                end
            end
            RUN: begin
                state_nxt_s = RUN;
            end
            default: begin
                state_nxt_s = SETTLE;
            end
        endcase
    end

    // Start-up FSM state, settle counter and registered sw_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= SETTLE;
            settle_cnt_r <= 22'd0;
            valid_r      <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            valid_r <= (state_nxt_s == RUN);
            if (state_r == SETTLE) begin
                settle_cnt_r <= settle_cnt_r + 22'd1;
            end else begin
                settle_cnt_r <= settle_cnt_r;
            end
        end
    end

    // Two-flop synchronizer for the asynchronous switch pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= {N_SW{1'b0}};
            sync2_r <= {N_SW{1'b0}};
        end else begin
            sync1_r <= sw;
            sync2_r <= sync1_r;
        end
    end

    // Per-bit acceptance decode, and edge events gated by the RUN state.
    always_comb begin
        events_en_s = (state_r == RUN);
        differ_s    = sync2_r ^ stable_r;
        accept_s    = {N_SW{1'b0}};
        for (int i = 0; i < N_SW; i++) begin
            accept_s[i] = differ_s[i] && (deb_cnt_r[i] == DEB_LAST);
        end
        rise_nxt_s = accept_s & sync2_r & {N_SW{events_en_s}};
        fall_nxt_s = accept_s & ~sync2_r & {N_SW{events_en_s}};
    end

    // Debounce counters and accepted levels. A glitch back to the accepted
    // level clears the count, even on the last cycle before acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable_r <= {N_SW{1'b0}};
            for (int i = 0; i < N_SW; i++) begin
                deb_cnt_r[i] <= 21'd0;
            end
        end else begin
            for (int i = 0; i < N_SW; i++) begin
                if (!differ_s[i]) begin
                    deb_cnt_r[i] <= 21'd0;
                end else if (accept_s[i]) begin
                    deb_cnt_r[i] <= 21'd0;
                    stable_r[i]  <= sync2_r[i];
                end else begin
                    deb_cnt_r[i] <= deb_cnt_r[i] + 21'd1;
                end
            end
        end
    end

    // Registered one-cycle rise/fall pulses, aligned with the sw_stable change.
    always_ff @(posedge clk) begin
        if (rst) begin
            rise_r <= {N_SW{1'b0}};
            fall_r <= {N_SW{1'b0}};
        end else begin
            rise_r <= rise_nxt_s;
            fall_r <= fall_nxt_s;
        end
    end

`ifdef SW_DEBOUNCE_RISE_CNT_EN
    logic [8*N_SW-1:0] rise_cnt_r;

    // Per-switch 8-bit rise counters, wrapping 255 -> 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            rise_cnt_r <= {(8*N_SW){1'b0}};
        end else begin
            for (int i = 0; i < N_SW; i++) begin
                if (rise_nxt_s[i]) begin
                    rise_cnt_r[8*i +: 8] <= rise_cnt_r[8*i +: 8] + 8'd1;
                end else begin
                    rise_cnt_r[8*i +: 8] <= rise_cnt_r[8*i +: 8];
                end
            end
        end
    end

    assign rise_cnt = rise_cnt_r;
`else
    assign rise_cnt = {(8*N_SW){1'b0}};
`endif

    assign sw_stable = stable_r;
    assign sw_rise   = rise_r;
    assign sw_fall   = fall_r;
    assign sw_valid  = valid_r;

endmodule
